// File: rtl/pe_dot_controller.sv
// pe_dot_controller: sequences one multiply-accumulate processing element
// through a dot product of programmable length. Operand pairs are accepted
// one at a time, the PE sum output is fed back as the next sum input, and
// the final sum is offered on a valid/ready result port together with a
// sticky wrap flag and a watchdog abort flag.
module pe_dot_controller #(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int LEN_W            = 8,
  parameter int TIMEOUT          = 64
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        cmd_start,
  input  logic [LEN_W-1:0]            cfg_len,
  input  logic [OUTPUT_PRECISION-1:0] cfg_bias,
  output logic                        busy,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [PRECISION-1:0]        op_a,
  input  logic [PRECISION-1:0]        op_b,
  output logic [PRECISION-1:0]        pe_a,
  output logic [PRECISION-1:0]        pe_b,
  output logic [OUTPUT_PRECISION-1:0] pe_s_in,
  output logic                        pe_start,
  input  logic                        pe_ready,
  input  logic [OUTPUT_PRECISION-1:0] pe_s_out,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [OUTPUT_PRECISION-1:0] res_data,
  output logic                        res_ovf,
  output logic                        res_err
);

  // Watchdog only has to count up to TIMEOUT-1 (TIMEOUT >= 2).
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                        state;
  logic [OUTPUT_PRECISION-1:0]   acc;
  logic [LEN_W-1:0]              len;
  logic [LEN_W-1:0]              count;
  logic [WD_W-1:0]               wd;
  logic                          ovf;
  logic                          err;

  // The accumulator is both the PE sum input and the reported result; it
  // only changes in IDLE (bias load) and on a PE completion, so it is
  // stable for the whole of WAIT and DONE.
  assign pe_s_in  = acc;
  assign res_data = acc;
  assign res_ovf  = ovf;
  assign res_err  = err;

  // Sequencer FSM with registered handshake outputs; every output flop is
  // updated on the same edge as the state transition that implies it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      len       <= '0;
      count     <= '0;
      wd        <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      pe_a      <= '0;
      pe_b      <= '0;
      busy      <= 1'b0;
      op_ready  <= 1'b0;
      pe_start  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_start) begin
            len  <= cfg_len;
            acc  <= cfg_bias;
            ovf  <= 1'b0;
            err  <= 1'b0;
            busy <= 1'b1;
            if (cfg_len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state    <= LOAD;
              op_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (op_valid) begin
            pe_a     <= op_a;
            pe_b     <= op_b;
            wd       <= '0;
            op_ready <= 1'b0;
            pe_start <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A completion on the final watchdog cycle still counts.
          if (pe_ready) begin
            acc      <= pe_s_out;
            ovf      <= ovf | (pe_s_out < acc);
            count    <= count + LEN_W'(1);
            pe_start <= 1'b0;
            if ((count + LEN_W'(1)) == len) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state    <= LOAD;
              op_ready <= 1'b1;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err       <= 1'b1;
            pe_start  <= 1'b0;
            state     <= DONE;
            res_valid <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
